// File: rtl/simple_pkg.sv
// rtl/simple_pkg.sv - shared opcodes, flag indices and memory-control encodings for the SIMPLE pipeline
package simple_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_CMP = 4'd5;
    localparam logic [3:0] OP_MOV = 4'd6;
    localparam logic [3:0] OP_NOP_A = 4'd7;
    localparam logic [3:0] OP_SLL = 4'd8;
    localparam logic [3:0] OP_SLR = 4'd9;
    localparam logic [3:0] OP_SRL = 4'd10;
    localparam logic [3:0] OP_SRA = 4'd11;
    localparam logic [3:0] OP_IN  = 4'd12;
    localparam logic [3:0] OP_OUT = 4'd13;
    localparam logic [3:0] OP_NOP_B = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_LOAD  = 2'b01;
    localparam logic [1:0] MEM_STORE = 2'b10;

    // Shifter kind matches opcode[1:0] of the shift group
    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SLR = 2'd1;
    localparam logic [1:0] SH_SRL = 2'd2;
    localparam logic [1:0] SH_SRA = 2'd3;

endpackage

// File: rtl/simple_shifter.sv
// rtl/simple_shifter.sv - combinational 16-bit shift/rotate unit with last-bit-out carry
module simple_shifter
    import simple_pkg::*;
(
    input  logic [15:0] value,
    input  logic [3:0]  shamt,
    input  logic [1:0]  kind,
    output logic [15:0] result,
    output logic        carry
);

    // Each widened form keeps the last bit shifted out in its extra position
    logic [16:0] sll_w;
    logic [31:0] rot_w;
    logic [16:0] srl_w;
    logic [16:0] sra_w;

    assign sll_w = {1'b0, value} << shamt;
    assign rot_w = {value, value} << shamt;
    assign srl_w = {value, 1'b0} >> shamt;
    assign sra_w = $signed({value, 1'b0}) >>> shamt;

    always_comb begin
        result = value;
        carry  = 1'b0;
        case (kind)
            SH_SLL: begin
                result = sll_w[15:0];
                carry  = sll_w[16];
            end
            SH_SLR: begin
                result = rot_w[31:16];
                carry  = (shamt != 4'd0) && rot_w[16];
            end
            SH_SRL: begin
                result = srl_w[16:1];
                carry  = srl_w[0];
            end
            default: begin
                result = sra_w[16:1];
                carry  = sra_w[0];
            end
        endcase
    end

endmodule

// File: rtl/simple_execute_stage.sv
// rtl/simple_execute_stage.sv - SIMPLE pipeline execute stage: ALU, shifter, flags, IN/OUT/HLT
module simple_execute_stage
    import simple_pkg::*;
#(
    parameter int         WIDTH       = 16,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic             clockp3,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] alu1,
    input  logic [WIDTH-1:0] alu2,
    input  logic [3:0]       opcode,
    input  logic [3:0]       shamt,
    input  logic             writereg_in,
    input  logic [1:0]       memwrite_in,
    input  logic [2:0]       regaddress_in,
    input  logic [WIDTH-1:0] address_in,
    input  logic [WIDTH-1:0] storedata_in,
    input  logic [WIDTH-1:0] inport,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             valid_out,
    output logic             writereg,
    output logic [1:0]       memwrite,
    output logic [2:0]       regaddress,
    output logic [WIDTH-1:0] address,
    output logic [WIDTH-1:0] storedata,
    output logic [WIDTH-1:0] outport,
    output logic             halted
);

    typedef enum logic {RUN, HALTED} state_t;
    state_t state;

    logic [15:0] sh_result;
    logic        sh_carry;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [15:0] alu_res;
    logic        res_we;
    logic        flag_we;
    logic        wr_next;
    logic        c_bit;
    logic        v_bit;
    logic [3:0]  flag_next;

    simple_shifter u_shifter (
        .value  (alu1),
        .shamt  (shamt),
        .kind   (opcode[1:0]),
        .result (sh_result),
        .carry  (sh_carry)
    );

    // Subtract borrow lands in diff[16], so C reads directly as "alu1 < alu2 unsigned"
    assign sum  = {1'b0, alu1} + {1'b0, alu2};
    assign diff = {1'b0, alu1} - {1'b0, alu2};

    always_comb begin
        alu_res   = result;
        res_we    = 1'b0;
        flag_we   = 1'b0;
        wr_next   = writereg_in;
        c_bit     = 1'b0;
        v_bit     = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res = sum[15:0];
                c_bit   = sum[16];
                v_bit   = (alu1[15] == alu2[15]) && (sum[15] != alu1[15]);
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[15:0];
                c_bit   = diff[16];
                v_bit   = (alu1[15] != alu2[15]) && (diff[15] != alu1[15]);
                res_we  = (opcode == OP_SUB);
                flag_we = 1'b1;
                if (opcode == OP_CMP) wr_next = 1'b0;
            end
            OP_AND: begin alu_res = alu1 & alu2; res_we = 1'b1; flag_we = 1'b1; end
            OP_OR:  begin alu_res = alu1 | alu2; res_we = 1'b1; flag_we = 1'b1; end
            OP_XOR: begin alu_res = alu1 ^ alu2; res_we = 1'b1; flag_we = 1'b1; end
            OP_MOV: begin alu_res = alu2;        res_we = 1'b1; flag_we = 1'b1; end
            OP_SLL, OP_SLR, OP_SRL, OP_SRA: begin
                alu_res = sh_result;
                c_bit   = sh_carry;
                res_we  = 1'b1;
                flag_we = 1'b1;
            end
            OP_IN:  begin alu_res = inport; res_we = 1'b1; end
            OP_OUT: wr_next = 1'b0;
            default: ;
        endcase
        flag_next = flags;
        if (flag_we) begin
            flag_next[FLAG_S] = alu_res[15];
            flag_next[FLAG_Z] = (alu_res == 16'd0);
            flag_next[FLAG_C] = c_bit;
            flag_next[FLAG_V] = v_bit;
        end
    end

    always_ff @(posedge clockp3) begin
        if (reset) begin
            state      <= RUN;
            result     <= '0;
            flags      <= 4'b0000;
            valid_out  <= 1'b0;
            writereg   <= 1'b0;
            memwrite   <= MEM_NONE;
            regaddress <= '0;
            address    <= '0;
            storedata  <= '0;
            outport    <= '0;
            halted     <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            writereg  <= 1'b0;
            memwrite  <= MEM_NONE;
            case (state)
                RUN: begin
                    if (in_valid && !flush) begin
                        regaddress <= regaddress_in;
                        address    <= address_in;
                        storedata  <= storedata_in;
                        if (opcode == HALT_OPCODE) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end else begin
                            valid_out <= 1'b1;
                            writereg  <= wr_next;
                            memwrite  <= memwrite_in;
                            flags     <= flag_next;
                            if (res_we) result <= alu_res;
                            if (opcode == OP_OUT) outport <= alu1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_execute_stage.sv
// tb/tb_simple_execute_stage.sv - directed table-driven bench for simple_execute_stage
module tb_simple_execute_stage;

    logic        clockp3 = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        flush;
    logic [15:0] alu1;
    logic [15:0] alu2;
    logic [3:0]  opcode;
    logic [3:0]  shamt;
    logic        writereg_in;
    logic [1:0]  memwrite_in;
    logic [2:0]  regaddress_in;
    logic [15:0] address_in;
    logic [15:0] storedata_in;
    logic [15:0] inport;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        valid_out;
    logic        writereg;
    logic [1:0]  memwrite;
    logic [2:0]  regaddress;
    logic [15:0] address;
    logic [15:0] storedata;
    logic [15:0] outport;
    logic        halted;

    simple_execute_stage dut (
        .clockp3       (clockp3),
        .reset         (reset),
        .in_valid      (in_valid),
        .flush         (flush),
        .alu1          (alu1),
        .alu2          (alu2),
        .opcode        (opcode),
        .shamt         (shamt),
        .writereg_in   (writereg_in),
        .memwrite_in   (memwrite_in),
        .regaddress_in (regaddress_in),
        .address_in    (address_in),
        .storedata_in  (storedata_in),
        .inport        (inport),
        .result        (result),
        .flags         (flags),
        .valid_out     (valid_out),
        .writereg      (writereg),
        .memwrite      (memwrite),
        .regaddress    (regaddress),
        .address       (address),
        .storedata     (storedata),
        .outport       (outport),
        .halted        (halted)
    );

    always #5 clockp3 = ~clockp3;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  sh;
        logic        vld;
        logic        fl;
        logic        wr;
        logic [1:0]  mem;
        logic [2:0]  ra;
        logic [15:0] addr;
        logic [15:0] sd;
        logic [15:0] inp;
        logic [15:0] e_res;
        logic [3:0]  e_fl;
        logic        e_v;
        logic        e_wr;
        logic [1:0]  e_mem;
        logic [15:0] e_out;
    } vec_t;

    localparam int NVEC = 20;
    vec_t tbl [NVEC];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic vld, input logic fl, input logic [1:0] mem);
        opcode = op; alu1 = a; alu2 = b; in_valid = vld; flush = fl;
        memwrite_in = mem; writereg_in = 1'b1; shamt = 4'd0;
        regaddress_in = 3'd1; address_in = 16'h0010; storedata_in = 16'h0020; inport = 16'h0;
    endtask

    task automatic tick();
        @(posedge clockp3);
        #1;
    endtask

    initial begin
        //            op     a        b        sh    vld   fl    wr    mem    ra    addr      sd        inp       e_res     e_fl  e_v   e_wr  e_mem  e_out
        tbl[0]  = '{4'd0,  16'h7FFF, 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 4'h9, 1'b1, 1'b1, 2'd0, 16'h0000};
        tbl[1]  = '{4'd1,  16'h0001, 16'h0002, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd2, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 4'hA, 1'b1, 1'b1, 2'd0, 16'h0000};
        tbl[2]  = '{4'd5,  16'h1234, 16'h1234, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd3, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 4'h4, 1'b1, 1'b0, 2'd0, 16'h0000};
        tbl[3]  = '{4'd8,  16'h8001, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 4'h2, 1'b1, 1'b1, 2'd0, 16'h0000};
        tbl[4]  = '{4'd11, 16'h8000, 16'h0000, 4'd4, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'hF800, 4'h8, 1'b1, 1'b1, 2'd0, 16'h0000};
        tbl[5]  = '{4'd9,  16'h8001, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0003, 4'h2, 1'b1, 1'b1, 2'd0, 16'h0000};
        tbl[6]  = '{4'd10, 16'h8001, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 4'h8, 1'b1, 1'b1, 2'd0, 16'h0000};
        tbl[7]  = '{4'd0,  16'h0001, 16'h0001, 4'd0, 1'b1, 1'b1, 1'b1, 2'd2, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 4'h8, 1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[8]  = '{4'd0,  16'h0001, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h8001, 4'h8, 1'b0, 1'b0, 2'd0, 16'h0000};
        tbl[9]  = '{4'd6,  16'h0000, 16'h5555, 4'd0, 1'b1, 1'b0, 1'b1, 2'd1, 3'd5, 16'h0040, 16'h1111, 16'h0000, 16'h5555, 4'h0, 1'b1, 1'b1, 2'd1, 16'h0000};
        tbl[10] = '{4'd13, 16'hBEEF, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 4'h0, 1'b1, 1'b0, 2'd0, 16'hBEEF};
        tbl[11] = '{4'd0,  16'hFFFF, 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1, 2'd2, 3'd6, 16'h0080, 16'h2222, 16'h0000, 16'h0000, 4'h6, 1'b1, 1'b1, 2'd2, 16'hBEEF};
        tbl[12] = '{4'd12, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'hA5A5, 16'hA5A5, 4'h6, 1'b1, 1'b1, 2'd0, 16'hBEEF};
        tbl[13] = '{4'd7,  16'h1111, 16'h2222, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5, 4'h6, 1'b1, 1'b1, 2'd0, 16'hBEEF};
        tbl[14] = '{4'd4,  16'hFFFF, 16'h00FF, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'hFF00, 4'h8, 1'b1, 1'b1, 2'd0, 16'hBEEF};
        tbl[15] = '{4'd1,  16'h8000, 16'h0001, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 4'h1, 1'b1, 1'b1, 2'd0, 16'hBEEF};
        tbl[16] = '{4'd2,  16'hF0F0, 16'hFF00, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'hF000, 4'h8, 1'b1, 1'b1, 2'd0, 16'hBEEF};
        tbl[17] = '{4'd3,  16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4'h4, 1'b1, 1'b1, 2'd0, 16'hBEEF};
        tbl[18] = '{4'd10, 16'h0003, 16'h0000, 4'd1, 1'b1, 1'b0, 1'b1, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 4'h2, 1'b1, 1'b1, 2'd0, 16'hBEEF};
        tbl[19] = '{4'd14, 16'h0000, 16'h0000, 4'd0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd1, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 4'h2, 1'b1, 1'b0, 2'd0, 16'hBEEF};

        reset = 1'b1;
        set_in(4'd0, 16'h1234, 16'h4321, 1'b1, 1'b0, 2'd2);
        tick();
        tick();
        check("rst result", result, 0);
        check("rst flags", flags, 0);
        check("rst valid", valid_out, 0);
        check("rst writereg", writereg, 0);
        check("rst memwrite", memwrite, 0);
        check("rst regaddress", regaddress, 0);
        check("rst address", address, 0);
        check("rst storedata", storedata, 0);
        check("rst outport", outport, 0);
        check("rst halted", halted, 0);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            opcode = tbl[i].op; alu1 = tbl[i].a; alu2 = tbl[i].b; shamt = tbl[i].sh;
            in_valid = tbl[i].vld; flush = tbl[i].fl; writereg_in = tbl[i].wr;
            memwrite_in = tbl[i].mem; regaddress_in = tbl[i].ra; address_in = tbl[i].addr;
            storedata_in = tbl[i].sd; inport = tbl[i].inp;
            tick();
            check($sformatf("v%0d result", i), result, tbl[i].e_res);
            check($sformatf("v%0d flags", i), flags, tbl[i].e_fl);
            check($sformatf("v%0d valid", i), valid_out, tbl[i].e_v);
            check($sformatf("v%0d writereg", i), writereg, tbl[i].e_wr);
            check($sformatf("v%0d memwrite", i), memwrite, tbl[i].e_mem);
            check($sformatf("v%0d outport", i), outport, tbl[i].e_out);
            if (tbl[i].vld && !tbl[i].fl) begin
                check($sformatf("v%0d regaddress", i), regaddress, tbl[i].ra);
                check($sformatf("v%0d address", i), address, tbl[i].addr);
                check($sformatf("v%0d storedata", i), storedata, tbl[i].sd);
            end
        end

        // Flushed HLT must not halt
        set_in(4'hF, 16'h0, 16'h0, 1'b1, 1'b1, 2'd0);
        tick();
        check("flushed hlt halted", halted, 0);
        check("flushed hlt valid", valid_out, 0);

        set_in(4'hF, 16'h0, 16'h0, 1'b1, 1'b0, 2'd0);
        tick();
        check("hlt halted", halted, 1);
        check("hlt valid", valid_out, 0);
        check("hlt writereg", writereg, 0);
        check("hlt result", result, 16'h0001);
        check("hlt flags", flags, 4'h2);

        set_in(4'd0, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 2'd2);
        tick();
        check("halted add valid", valid_out, 0);
        check("halted add writereg", writereg, 0);
        check("halted add memwrite", memwrite, 0);
        check("halted add flags", flags, 4'h2);
        check("halted add result", result, 16'h0001);
        check("halted add halted", halted, 1);

        set_in(4'd13, 16'h1234, 16'h0, 1'b1, 1'b0, 2'd0);
        tick();
        check("halted out outport", outport, 16'hBEEF);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2 halted", halted, 0);
        check("rst2 result", result, 0);
        check("rst2 flags", flags, 0);
        check("rst2 outport", outport, 0);
        check("rst2 valid", valid_out, 0);
        check("rst2 address", address, 0);

        set_in(4'd0, 16'h0001, 16'h0002, 1'b1, 1'b0, 2'd0);
        tick();
        check("post add result", result, 16'h0003);
        check("post add flags", flags, 4'h0);
        check("post add valid", valid_out, 1);
        check("post add writereg", writereg, 1);
        check("post add halted", halted, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
